// File: rtl/synth_voice_sequencer.sv
// synth_voice_sequencer
//   Multi-voice DDS phase-accumulator engine. On each sample tick the voices
//   are swept serially, one per clk. Each voice's phase advances by its tuning
//   word, and the top ADDR_W phase bits are emitted as a wavetable ROM address.
//   f_note = f_tick * inc / 2^PHASE_W.
//
//   Optional feature, enabled by defining SYNTH_GLIDE_EN:
//   Portamento. Each voice's current tuning word moves towards the written
//   target by (target - current) >>> GLIDE_SHIFT on every update.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   tick          sample-rate strobe, 1 clk wide
//   cfg_valid/cfg_ready, cfg_voice, cfg_inc, cfg_gate
//                 voice config write; accepted only while idle
//   out_valid     out_voice/out_addr/out_active hold one voice result
//   sweep_done    pulses together with the last voice's result
//   overrun       sticky flag: a tick arrived while sweeping; cleared by ovr_clr
module synth_voice_sequencer #(
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_W     = 16,
    parameter int ADDR_W      = 10,
    parameter int GLIDE_SHIFT = 2,
    localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [VW-1:0]      cfg_voice,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic               cfg_gate,
    output logic               out_valid,
    output logic [VW-1:0]      out_voice,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_active,
    output logic               sweep_done,
    output logic               overrun,
    input  logic               ovr_clr
);

    if (ADDR_W > PHASE_W || GLIDE_SHIFT < 0 || NUM_VOICES < 1) begin : g_bad_params
        $error("synth_voice_sequencer: illegal parameter combination");
    end

    localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state, state_nxt;
    logic [VW-1:0]     idx, idx_nxt;

    logic [PHASE_W-1:0] phase [NUM_VOICES];
    logic               gate  [NUM_VOICES];
`ifdef SYNTH_GLIDE_EN
    logic [PHASE_W-1:0] cur_inc [NUM_VOICES];
    logic [PHASE_W-1:0] tgt_inc [NUM_VOICES];
    logic signed [PHASE_W:0] glide_diff, glide_step;
`else
    logic [PHASE_W-1:0] inc [NUM_VOICES];
`endif

    logic [PHASE_W-1:0] step_inc;   // tuning word applied in this update
    logic [PHASE_W-1:0] phase_sum;  // new phase of the voice being updated
    logic               cfg_wr;

    assign cfg_ready = (state == IDLE);
    // Writes to a voice index beyond NUM_VOICES complete the handshake but are dropped.
    assign cfg_wr    = cfg_valid && cfg_ready && ({1'b0, cfg_voice} < (VW+1)'(NUM_VOICES));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of block ordering.
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state and voice-update arithmetic
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                idx_nxt = idx + 1'b1;
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef SYNTH_GLIDE_EN
        glide_diff = $signed({1'b0, tgt_inc[idx]}) - $signed({1'b0, cur_inc[idx]});
        glide_step = glide_diff >>> GLIDE_SHIFT;
        // A small residual difference would otherwise never close; force a 1-LSB step.
        if (glide_diff != '0 && glide_step == '0)
            glide_step = glide_diff[PHASE_W] ? {(PHASE_W+1){1'b1}} : (PHASE_W+1)'(1);
        step_inc = PHASE_W'({1'b0, cur_inc[idx]} + glide_step);
`else
        step_inc = inc[idx];
`endif
        phase_sum = phase[idx] + step_inc;
    end

    // Per-voice storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the voice arrays are small register files that must start
            // silent, so they are reset explicitly rather than inferred as RAM.
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v]   <= '0;
                gate[v]    <= 1'b0;
`ifdef SYNTH_GLIDE_EN
                cur_inc[v] <= '0;
                tgt_inc[v] <= '0;
`else
                inc[v]     <= '0;
`endif
            end
        end else if (cfg_wr) begin
            gate[cfg_voice]    <= cfg_gate;
`ifdef SYNTH_GLIDE_EN
            tgt_inc[cfg_voice] <= cfg_inc;
            // A note starting from silence jumps straight to pitch.
            if (!gate[cfg_voice] && cfg_gate)
                cur_inc[cfg_voice] <= cfg_inc;
`else
            inc[cfg_voice]     <= cfg_inc;
`endif
        end else if (state == SWEEP) begin
            phase[idx]   <= gate[idx] ? phase_sum : '0;
`ifdef SYNTH_GLIDE_EN
            cur_inc[idx] <= step_inc;
`endif
        end
    end

    // Registered result stream and overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_voice  <= '0;
            out_addr   <= '0;
            out_active <= 1'b0;
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            sweep_done <= 1'b0;
            if (state == SWEEP) begin
                out_valid  <= 1'b1;
                out_voice  <= idx;
                out_addr   <= gate[idx] ? phase_sum[PHASE_W-1 -: ADDR_W] : '0;
                out_active <= gate[idx];
                sweep_done <= (idx == LAST);
            end
            // Set has priority over clear.
            if (tick && state == SWEEP)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_synth_voice_sequencer.sv
// tb_synth_voice_sequencer
//   Directed bench for synth_voice_sequencer (NUM_VOICES=4, PHASE_W=16,
//   ADDR_W=10). A sweep-level behavioural model predicts every result and is
//   compared every cycle; directed literal expectations pin the model.
module tb_synth_voice_sequencer;

    localparam int NV = 4;
    localparam int PW = 16;
    localparam int AW = 10;
    localparam int GS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_voice = '0;
    logic [PW-1:0] cfg_inc = '0;
    logic          cfg_gate = 1'b0;
    logic          out_valid;
    logic [1:0]    out_voice;
    logic [AW-1:0] out_addr;
    logic          out_active;
    logic          sweep_done;
    logic          overrun;
    logic          ovr_clr = 1'b0;

    synth_voice_sequencer #(.NUM_VOICES(NV), .PHASE_W(PW), .ADDR_W(AW), .GLIDE_SHIFT(GS)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
        .cfg_inc(cfg_inc), .cfg_gate(cfg_gate),
        .out_valid(out_valid), .out_voice(out_voice), .out_addr(out_addr),
        .out_active(out_active), .sweep_done(sweep_done),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int voice;
        int addr;
        int active;
        int done;
    } exp_t;

    int   m_phase [NV];
    int   m_inc   [NV];   // target word in the glide build
    int   m_cur   [NV];   // glide build only: word actually applied
    int   m_gate  [NV];
    int   m_busy;         // sweep cycles still to come
    int   m_ovr;
    int   m_valid;
    exp_t m_exp;
    exp_t m_q[$];

    // Advances one voice by one sample and returns what the DUT must emit.
    function automatic exp_t model_voice(input int v);
        exp_t e;
        int   d, s, w;
`ifdef SYNTH_GLIDE_EN
        d = m_inc[v] - m_cur[v];
        s = d >>> GS;
        if (d != 0 && s == 0) s = (d > 0) ? 1 : -1;
        m_cur[v] = (m_cur[v] + s) & 32'hFFFF;
        w = m_cur[v];
`else
        d = 0; s = 0;
        w = m_inc[v];
`endif
        if (m_gate[v] != 0) m_phase[v] = (m_phase[v] + w) % 65536;
        else                m_phase[v] = 0;
        e.voice  = v;
        e.addr   = m_phase[v] / 64;
        e.active = m_gate[v];
        e.done   = (v == NV - 1) ? 1 : 0;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                m_phase[v] = 0; m_inc[v] = 0; m_cur[v] = 0; m_gate[v] = 0;
            end
            m_busy = 0; m_ovr = 0; m_valid = 0;
            m_q.delete();
        end else if (m_busy > 0) begin
            m_valid = 1;
            m_exp   = m_q.pop_front();
            if (tick) m_ovr = 1;
            else if (ovr_clr) m_ovr = 0;
            m_busy--;
        end else begin
            m_valid = 0;
            if (ovr_clr) m_ovr = 0;
            if (cfg_valid) begin
`ifdef SYNTH_GLIDE_EN
                if (m_gate[cfg_voice] == 0 && cfg_gate) m_cur[cfg_voice] = int'(cfg_inc);
`endif
                m_inc[cfg_voice]  = int'(cfg_inc);
                m_gate[cfg_voice] = int'(cfg_gate);
            end
            if (tick) begin
                for (int v = 0; v < NV; v++) m_q.push_back(model_voice(v));
                m_busy = NV;
            end
        end
    end

    // ---------------- per-cycle compare + observation log ----------------
    bit checking = 1'b0;
    int seen_addr   [NV];
    int seen_active [NV];
    int valid_cnt;
    int done_voice;
    int done_cnt;

    always @(negedge clk) begin
        if (checking) begin
            check("cfg_ready", 32'(cfg_ready), 32'(m_busy == 0));
            check("overrun",   32'(overrun),   32'(m_ovr));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid != 0) begin
                check("out_voice",  32'(out_voice),  32'(m_exp.voice));
                check("out_addr",   32'(out_addr),   32'(m_exp.addr));
                check("out_active", 32'(out_active), 32'(m_exp.active));
                check("sweep_done", 32'(sweep_done), 32'(m_exp.done));
            end else begin
                check("sweep_done_idle", 32'(sweep_done), 32'd0);
            end
        end
        if (!rst && out_valid) begin
            seen_addr[out_voice]   = int'(out_addr);
            seen_active[out_voice] = int'(out_active);
            valid_cnt++;
            if (sweep_done) begin
                done_voice = int'(out_voice);
                done_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !cfg_ready; i++) step();
        check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    endtask

    task automatic cfg_write(input int v, input logic [PW-1:0] inc, input logic g);
        wait_ready();
        cfg_valid = 1'b1; cfg_voice = 2'(v); cfg_inc = inc; cfg_gate = g;
        step();
        cfg_valid = 1'b0;
    endtask

    // One tick, then enough cycles for the full sweep to be observed.
    task automatic sweep();
        wait_ready();
        valid_cnt = 0; done_cnt = 0; done_voice = -1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (NV + 2) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #1 checking = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr",  32'(out_addr),  32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_overrun",   32'(overrun),   32'd0);

        // Reset mid-sweep aborts the sweep
        cfg_write(1, 16'h1000, 1'b1);
        tick = 1'b1; step(); tick = 1'b0;
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_out_addr",  32'(out_addr),  32'd0);
        check("rstmid_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rstmid_overrun",   32'(overrun),   32'd0);
        step();
        rst = 1'b0;
        valid_cnt = 0;
        repeat (4) step();
        check("rstmid_no_more_valid", 32'(valid_cnt), 32'd0);

        // Single voice at 0x0040: one address step per sample
        cfg_write(0, 16'h0040, 1'b1);
        for (int t = 1; t <= 3; t++) begin
            sweep();
            check("v0_addr", 32'(seen_addr[0]), 32'(t));
            for (int v = 1; v < NV; v++) begin
                check("silent_addr",   32'(seen_addr[v]),   32'd0);
                check("silent_active", 32'(seen_active[v]), 32'd0);
            end
        end

        // Half-scale word wraps every second sample; sweep_done on the last voice
        cfg_write(2, 16'h8000, 1'b1);
        for (int t = 1; t <= 3; t++) begin
            sweep();
            check("v2_addr",    32'(seen_addr[2]), (t % 2 == 1) ? 32'd512 : 32'd0);
            check("v0_addr_b",  32'(seen_addr[0]), 32'(3 + t));
            check("done_voice", 32'(done_voice),   32'd3);
            check("done_cnt",   32'(done_cnt),     32'd1);
            check("valid_cnt",  32'(valid_cnt),    32'd4);
        end

        // Gate off silences and zeroes the phase; gate on restarts from zero
        cfg_write(0, 16'h0040, 1'b0);
        sweep();
        check("v0_off_addr",   32'(seen_addr[0]),   32'd0);
        check("v0_off_active", 32'(seen_active[0]), 32'd0);
        cfg_write(0, 16'h0040, 1'b1);
        sweep();
        check("v0_restart_addr",   32'(seen_addr[0]),   32'd1);
        check("v0_restart_active", 32'(seen_active[0]), 32'd1);

        // Same-edge write and tick: the sweep uses the new word
        wait_ready();
        valid_cnt = 0;
        cfg_valid = 1'b1; cfg_voice = 2'd1; cfg_inc = 16'h0400; cfg_gate = 1'b1;
        tick = 1'b1;
        step();
        cfg_valid = 1'b0; tick = 1'b0;
        repeat (NV + 2) step();
        check("sameedge_v1_addr", 32'(seen_addr[1]), 32'd16);

        // inc = 0 with gate on holds the phase
        cfg_write(1, 16'h0000, 1'b1);
        sweep();
        check("hold_v1_addr",   32'(seen_addr[1]),   32'd16);
        check("hold_v1_active", 32'(seen_active[1]), 32'd1);

        // Tick during a sweep: ignored, flags overrun
        wait_ready();
        valid_cnt = 0;
        tick = 1'b1; step(); tick = 1'b0;
        step();
        tick = 1'b1; step(); tick = 1'b0;
        repeat (NV + 4) step();
        check("ovr_valid_cnt", 32'(valid_cnt), 32'd4);
        check("ovr_set",       32'(overrun),   32'd1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        check("ovr_cleared",   32'(overrun),   32'd0);

        // Set wins over a simultaneous clear
        tick = 1'b1; step(); tick = 1'b0;
        step();
        tick = 1'b1; ovr_clr = 1'b1; step(); tick = 1'b0; ovr_clr = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        repeat (NV + 2) step();
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;

`ifdef SYNTH_GLIDE_EN
        // Glide 0x0100 -> 0x0200: words 0x140, 0x170, 0x194
        cfg_write(3, 16'h0100, 1'b1);
        sweep();
        check("glide_start_addr", 32'(seen_addr[3]), 32'd4);
        cfg_write(3, 16'h0200, 1'b1);
        sweep();
        check("glide_addr1", 32'(seen_addr[3]), 32'd9);
        sweep();
        check("glide_addr2", 32'(seen_addr[3]), 32'd14);
        sweep();
        check("glide_addr3", 32'(seen_addr[3]), 32'd21);
`endif

        repeat (3) step();
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
